// File: rtl/byte_lane_split.sv
// Sized load/store to word-aligned bus beats with lane selects, shifted write data and merged read data.
// Optional feature macro: BYTE_LANE_SPLIT_MISALIGN_EN enables splitting of word-crossing accesses.
module byte_lane_split #(
  parameter int BYTE_NUM = 8,
  parameter int ADDR_W   = 32,
  parameter int OFS_W    = $clog2(BYTE_NUM),
  parameter int SIZE_W   = OFS_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [SIZE_W-1:0]     req_size,
  input  logic                  req_we,
  input  logic                  req_mask,
  input  logic [8*BYTE_NUM-1:0] req_wdata,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [BYTE_NUM-1:0]   bus_bsel,
  output logic                  bus_we,
  output logic [8*BYTE_NUM-1:0] bus_wdata,
  output logic                  bus_last,
  input  logic [8*BYTE_NUM-1:0] bus_rdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [8*BYTE_NUM-1:0] rsp_rdata
);
  localparam int DW = 8 * BYTE_NUM;
  localparam int NW = OFS_W + 2;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  state_t r_state, w_next;

  logic [ADDR_W-1:0]   r_addr;
  logic [SIZE_W-1:0]   r_size;
  logic                r_we, r_mask;
  logic [DW-1:0]       r_wdata;

  function automatic logic [NW-1:0] f_nbytes(input logic [SIZE_W-1:0] s);
    logic [NW-1:0] n;
    n = '0;
    for (int i = 0; i < SIZE_W; i++)
      if (s[i]) n = NW'(1) << i;
    return n;
  endfunction

  logic w_req_onehot, w_req_ok;
  assign w_req_onehot = (req_size != '0) && ((req_size & (req_size - SIZE_W'(1))) == '0);

`ifdef BYTE_LANE_SPLIT_MISALIGN_EN
  assign w_req_ok = req_mask | w_req_onehot;
`else
  logic w_req_cross;
  assign w_req_cross = (NW'(req_addr[OFS_W-1:0]) + f_nbytes(req_size)) > NW'(BYTE_NUM);
  assign w_req_ok    = req_mask | (w_req_onehot & !w_req_cross);
`endif

  logic [OFS_W-1:0]           w_off;
  logic [NW-1:0]              w_n;
  logic [BYTE_NUM-1:0]        w_nmask, w_bsel_lo;
  logic [DW-1:0]              w_nbits, w_wd_lo, w_rd_shift, w_fin;
  logic [ADDR_W-OFS_W-1:0]    w_word;
  logic                       w_more;

  assign w_off      = r_addr[OFS_W-1:0];
  assign w_word     = r_addr[ADDR_W-1:OFS_W];
  assign w_n        = f_nbytes(r_size);
  assign w_rd_shift = bus_rdata >> {w_off, 3'b000};

  always_comb begin
    w_nmask = '0;
    w_nbits = '0;
    for (int b = 0; b < BYTE_NUM; b++) begin
      w_nmask[b]         = NW'(b) < w_n;
      w_nbits[8*b +: 8]  = {8{w_nmask[b]}};
    end
  end

`ifdef BYTE_LANE_SPLIT_MISALIGN_EN
  // Double-width shifts: low half is beat 0, high half spills into beat 1.
  logic [2*BYTE_NUM-1:0] w_bsel2;
  logic [2*DW-1:0]       w_wd2;
  logic [OFS_W:0]        w_roff;
  logic [DW-1:0]         r_rd0, w_merge;
  assign w_bsel2   = {{BYTE_NUM{1'b0}}, w_nmask} << w_off;
  assign w_wd2     = {{DW{1'b0}}, r_wdata} << {w_off, 3'b000};
  assign w_bsel_lo = w_bsel2[BYTE_NUM-1:0];
  assign w_wd_lo   = w_wd2[DW-1:0];
  assign w_more    = !r_mask && ((NW'(w_off) + w_n) > NW'(BYTE_NUM));
  assign w_roff    = (OFS_W+1)'(BYTE_NUM) - {1'b0, w_off};
  assign w_merge   = r_rd0 | (bus_rdata << {w_roff, 3'b000});
`else
  assign w_bsel_lo = w_nmask << w_off;
  assign w_wd_lo   = r_wdata << {w_off, 3'b000};
  assign w_more    = 1'b0;
`endif

  always_comb begin
    w_fin = w_rd_shift;
`ifdef BYTE_LANE_SPLIT_MISALIGN_EN
    if (r_state == BEAT1) w_fin = w_merge;
`endif
    w_fin = w_fin & w_nbits;
    if (r_mask) w_fin = bus_rdata;
    if (r_we)   w_fin = '0;
  end

  always_comb begin
    w_next    = r_state;
    bus_valid = 1'b0;
    bus_addr  = '0;
    bus_bsel  = '0;
    bus_we    = 1'b0;
    bus_wdata = '0;
    bus_last  = 1'b0;
    case (r_state)
      IDLE:  if (req_valid) w_next = w_req_ok ? BEAT0 : RESP;
      BEAT0: begin
        bus_valid = 1'b1;
        bus_addr  = {w_word, {OFS_W{1'b0}}};
        bus_bsel  = r_mask ? '1 : w_bsel_lo;
        bus_wdata = r_mask ? r_wdata : w_wd_lo;
        bus_we    = r_we;
        bus_last  = !w_more;
        if (bus_ready) w_next = w_more ? BEAT1 : RESP;
      end
`ifdef BYTE_LANE_SPLIT_MISALIGN_EN
      BEAT1: begin
        bus_valid = 1'b1;
        bus_addr  = {w_word + 1'b1, {OFS_W{1'b0}}};
        bus_bsel  = w_bsel2[2*BYTE_NUM-1:BYTE_NUM];
        bus_wdata = w_wd2[2*DW-1:DW];
        bus_we    = r_we;
        bus_last  = 1'b1;
        if (bus_ready) w_next = RESP;
      end
`endif
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign req_ready = (r_state == IDLE) && !rst;
  assign rsp_valid = (r_state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_size    <= '0;
      r_we      <= 1'b0;
      r_mask    <= 1'b0;
      r_wdata   <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
`ifdef BYTE_LANE_SPLIT_MISALIGN_EN
      r_rd0     <= '0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (req_valid) begin
          r_addr  <= req_addr;
          r_size  <= req_size;
          r_we    <= req_we;
          r_mask  <= req_mask;
          r_wdata <= req_wdata;
          if (!w_req_ok) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        BEAT0: if (bus_ready) begin
          if (w_more) begin
`ifdef BYTE_LANE_SPLIT_MISALIGN_EN
            r_rd0 <= w_rd_shift;
`endif
          end else begin
            rsp_err   <= 1'b0;
            rsp_rdata <= w_fin;
          end
        end
        BEAT1: if (bus_ready) begin
          rsp_err   <= 1'b0;
          rsp_rdata <= w_fin;
        end
        default: ;
      endcase
    end
  end
endmodule
